nx_fifo_unpack: RTL and testbench



---
 rtl/nx_fifo_unpack_pkg.sv | 19 +
 rtl/nx_fifo_unpack_stats.sv | 36 +++
 rtl/nx_fifo_unpack.sv | 99 +++++++++
 tb/tb_nx_fifo_unpack.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nx_fifo_unpack_pkg.sv
// Shared types and sizing helpers for the nx_fifo_unpack drain stage.
package nx_fifo_unpack_pkg;

   localparam int STAT_W = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } stage_e;

   function automatic int calc_n(input int in_w, input int out_w);
      return in_w / out_w;
   endfunction

   function automatic int calc_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nx_fifo_unpack_stats.sv
// Saturating word/beat counters for nx_fifo_unpack (built only with NX_FIFO_UNPACK_STATS_EN).
module nx_fifo_unpack_stats
   import nx_fifo_unpack_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc_words,
   input  logic              inc_beats,
   output logic [STAT_W-1:0] stat_words,
   output logic [STAT_W-1:0] stat_beats
);

   logic [STAT_W-1:0] words_q, words_d;
   logic [STAT_W-1:0] beats_q, beats_d;

   always_comb begin
      words_d = words_q;
      beats_d = beats_q;
      if (inc_words && (words_q != '1)) words_d = words_q + STAT_W'(1);
      if (inc_beats && (beats_q != '1)) beats_d = beats_q + STAT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         words_q <= '0;
         beats_q <= '0;
      end else begin
         words_q <= words_d;
         beats_q <= beats_d;
      end
   end

   assign stat_words = words_q;
   assign stat_beats = beats_q;

endmodule

// File: rtl/nx_fifo_unpack.sv
// Pops IN_W-bit FIFO words and replays each as IN_W/OUT_W little-endian beats on valid/ready.
// Optional saturating statistics outputs are enabled by defining NX_FIFO_UNPACK_STATS_EN.
module nx_fifo_unpack
   import nx_fifo_unpack_pkg::*;
#(
   parameter int IN_W  = 128,
   parameter int OUT_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              fifo_empty,
   input  logic [IN_W-1:0]   fifo_rdata,
   output logic              fifo_ren,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_sow,
   output logic              out_eow
`ifdef NX_FIFO_UNPACK_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_words,
   output logic [STAT_W-1:0] stat_beats
`endif
);

   localparam int N     = calc_n(IN_W, OUT_W);
   localparam int IDX_W = calc_idx_w(N);

   if (((IN_W % OUT_W) != 0) || (N < 2)) begin : g_param_check
      $error("nx_fifo_unpack: IN_W must be a multiple of OUT_W giving at least two beats");
   end

   stage_e                  state_q, state_d;
   logic [IN_W-1:0]         hold_q, hold_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    hold_vld;
   logic                    acc;
   logic                    last;
   logic [N-1:0][OUT_W-1:0] lanes;

   assign hold_vld = (state_q == ST_BUSY);
   assign last     = (idx_q == IDX_W'(N - 1));
   assign acc      = hold_vld & out_ready;
   // Popping on the final accept lets the next word follow with no bubble.
   assign fifo_ren = !fifo_empty & !clear & (!hold_vld | (acc & last));

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      hold_d  = hold_q;
      idx_d   = idx_q;
      if (clear) begin
         state_d = ST_IDLE;
         idx_d   = '0;
      end else if (fifo_ren) begin
         state_d = ST_BUSY;
         hold_d  = fifo_rdata;
         idx_d   = '0;
      end else if (acc && last) begin
         state_d = ST_IDLE;
         idx_d   = '0;
      end else if (acc) begin
         idx_d   = idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         // NOTE: the wide staging register is reset too, so out_data reads zero out of reset.
         hold_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
      end
   end

   assign lanes     = hold_q;
   assign out_valid = hold_vld;
   assign out_data  = lanes[idx_q];
   assign out_sow   = hold_vld & (idx_q == '0);
   assign out_eow   = hold_vld & last;

`ifdef NX_FIFO_UNPACK_STATS_EN
   nx_fifo_unpack_stats u_stats (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc_words  (fifo_ren),
      .inc_beats  (acc),
      .stat_words (stat_words),
      .stat_beats (stat_beats)
   );
`endif

endmodule

// File: tb/tb_nx_fifo_unpack.sv
// Self-checking bench for nx_fifo_unpack: queue-based FIFO plus a beat-stream reference model.
module tb_nx_fifo_unpack;

   localparam int IN_W  = 128;
   localparam int OUT_W = 32;
   localparam int N     = IN_W / OUT_W;

   typedef struct {
      logic [OUT_W-1:0] data;
      bit               sow;
      bit               eow;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              clear;
   logic              fifo_empty;
   logic [IN_W-1:0]   fifo_rdata;
   logic              fifo_ren;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_data;
   logic              out_sow;
   logic              out_eow;
`ifdef NX_FIFO_UNPACK_STATS_EN
   logic [31:0]       stat_words;
   logic [31:0]       stat_beats;
`endif

   nx_fifo_unpack #(.IN_W(IN_W), .OUT_W(OUT_W)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_ren   (fifo_ren),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_sow    (out_sow),
      .out_eow    (out_eow)
`ifdef NX_FIFO_UNPACK_STATS_EN
      ,
      .stat_words (stat_words),
      .stat_beats (stat_beats)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [IN_W-1:0]  fq[$];
   beat_t            exp_q[$];
   logic [OUT_W-1:0] log_q[$];
   bit               sow_log[$];
   bit               eow_log[$];

   bit               m_busy = 1'b0;
   int               m_left = 0;
   longint           m_words = 0;
   longint           m_beats = 0;
   int               ren_cnt = 0;

   logic             s_valid, s_ren, s_sow, s_eow;
   logic [OUT_W-1:0] s_data;

   task automatic check(input string nm, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic push_word(input logic [IN_W-1:0] w);
      beat_t b;
      fq.push_back(w);
      for (int j = 0; j < N; j++) begin
         b.data = w[j*OUT_W +: OUT_W];
         b.sow  = (j == 0);
         b.eow  = (j == N - 1);
         exp_q.push_back(b);
      end
   endtask

   task automatic drive_fifo();
      fifo_empty = (fq.size() == 0);
      fifo_rdata = (fq.size() == 0) ? '0 : fq[0];
   endtask

   task automatic drop_staged();
      for (int k = 0; k < m_left; k++)
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      m_busy = 1'b0;
      m_left = 0;
   endtask

   // One clock cycle: drive inputs, compare against the model mid-cycle, then advance model and FIFO.
   task automatic step(input bit rdy, input bit clr, input int npush);
      bit e_ren;
      bit m_acc;
      out_ready = rdy;
      clear     = clr;
      for (int k = 0; k < npush; k++) push_word({$urandom, $urandom, $urandom, $urandom});
      drive_fifo();
      @(negedge clk);
      e_ren = (fq.size() != 0) && !clr && (!m_busy || (rdy && m_left == 1));
      m_acc = m_busy && rdy;
      check("out_valid", IN_W'(out_valid), IN_W'(m_busy));
      check("fifo_ren", IN_W'(fifo_ren), IN_W'(e_ren));
      if (m_busy && exp_q.size() > 0) begin
         check("out_data", IN_W'(out_data), IN_W'(exp_q[0].data));
         check("out_sow", IN_W'(out_sow), IN_W'(exp_q[0].sow));
         check("out_eow", IN_W'(out_eow), IN_W'(exp_q[0].eow));
      end
`ifdef NX_FIFO_UNPACK_STATS_EN
      check("stat_words", IN_W'(stat_words), IN_W'(m_words));
      check("stat_beats", IN_W'(stat_beats), IN_W'(m_beats));
`endif
      s_valid = out_valid;
      s_ren   = fifo_ren;
      s_data  = out_data;
      s_sow   = out_sow;
      s_eow   = out_eow;
      @(posedge clk);
      if (s_valid && rdy) begin
         log_q.push_back(s_data);
         sow_log.push_back(s_sow);
         eow_log.push_back(s_eow);
      end
      if (s_ren) begin
         ren_cnt++;
         if (fq.size() > 0) void'(fq.pop_front());
      end
      if (e_ren && m_words < 64'hFFFF_FFFF) m_words++;
      if (m_acc && m_beats < 64'hFFFF_FFFF) m_beats++;
      if (clr) begin
         drop_staged();
      end else begin
         if (m_acc) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            m_left--;
         end
         if (e_ren) begin
            m_busy = 1'b1;
            m_left = N;
         end else if (m_busy && m_left == 0) begin
            m_busy = 1'b0;
         end
      end
      #1;
   endtask

   initial begin
      int base;
      int ren0;
      rst_n      = 1'b0;
      clear      = 1'b0;
      out_ready  = 1'b0;
      drive_fifo();

      // Reset state
      @(negedge clk);
      check("rst_out_valid", IN_W'(out_valid), '0);
      check("rst_out_data", IN_W'(out_data), '0);
      check("rst_out_sow", IN_W'(out_sow), '0);
      check("rst_out_eow", IN_W'(out_eow), '0);
      check("rst_fifo_ren", IN_W'(fifo_ren), '0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single word, full-rate consumer
      base = log_q.size();
      ren0 = ren_cnt;
      push_word(128'h4444_4444_3333_3333_2222_2222_1111_1111);
      step(1, 0, 0);
      check("single_ren", IN_W'(s_ren), IN_W'(1));
      check("single_latency", IN_W'(s_valid), '0);
      repeat (N) step(1, 0, 0);
      check("single_beat0", IN_W'(log_q[base+0]), IN_W'(32'h1111_1111));
      check("single_beat1", IN_W'(log_q[base+1]), IN_W'(32'h2222_2222));
      check("single_beat2", IN_W'(log_q[base+2]), IN_W'(32'h3333_3333));
      check("single_beat3", IN_W'(log_q[base+3]), IN_W'(32'h4444_4444));
      check("single_sow0", IN_W'(sow_log[base+0]), IN_W'(1));
      check("single_sow1", IN_W'(sow_log[base+1]), '0);
      check("single_eow3", IN_W'(eow_log[base+3]), IN_W'(1));
      step(1, 0, 0);
      check("single_idle", IN_W'(s_valid), '0);
      check("single_ren_count", IN_W'(ren_cnt - ren0), IN_W'(1));

      // Throughput: four preloaded words stream as 16 contiguous beats
      base = log_q.size();
      step(1, 0, 4);
      repeat (16) step(1, 0, 0);
      check("thru_beats", IN_W'(log_q.size() - base), IN_W'(16));
      step(1, 0, 0);
      check("thru_idle", IN_W'(s_valid), '0);

      // Backpressure pattern 1,0,0
      base = log_q.size();
      for (int i = 0; i < 30; i++) step(i % 3 == 0, 0, (i == 0) ? 2 : 0);
      check("bp_beats", IN_W'(log_q.size() - base), IN_W'(8));

      // Clear on beat 2 of 4 with another word queued
      step(1, 0, 2);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 1, 0);
      check("clr_valid_in_cycle", IN_W'(s_valid), IN_W'(1));
      check("clr_no_ren", IN_W'(s_ren), '0);
      step(1, 0, 0);
      check("clr_valid_after", IN_W'(s_valid), '0);
      check("clr_reload_ren", IN_W'(s_ren), IN_W'(1));
      step(1, 0, 0);
      check("clr_next_sow", IN_W'(s_sow), IN_W'(1));
      repeat (N) step(1, 0, 0);
      check("clr_drained", IN_W'(s_valid), '0);

      // Asynchronous reset in the middle of a word
      push_word(128'hDDDD_0003_CCCC_0002_BBBB_0001_AAAA_0000);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", IN_W'(out_valid), '0);
      check("arst_sow", IN_W'(out_sow), '0);
      drop_staged();
      m_words = 0;
      m_beats = 0;
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      push_word(128'h0000_0004_0000_0003_0000_0002_5A5A_0001);
      step(1, 0, 0);
      check("arst_ren", IN_W'(s_ren), IN_W'(1));
      step(1, 0, 0);
      check("arst_first_sow", IN_W'(s_sow), IN_W'(1));
      check("arst_first_data", IN_W'(s_data), IN_W'(32'h5A5A_0001));
      repeat (N) step(1, 0, 0);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 3) != 0,
              $urandom_range(0, 49) == 0,
              (fq.size() < 6 && $urandom_range(0, 2) == 0) ? 1 : 0);
      end
      repeat (40) step(1, 0, 0);
      check("end_fifo_empty", IN_W'(fq.size()), '0);
      check("end_model_empty", IN_W'(exp_q.size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
